// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target memory port
package i2c_pkg;

  localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h50;

  // SDA level driven or seen during the acknowledge bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK
  } i2c_state_e;

  // Register-style request seen from the i2c_axi_lite side of the bus
  typedef struct packed {
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
  } i2c_axi_lite_req_t;

  // First byte after START: 7-bit device address followed by the read flag
  function automatic logic [7:0] i2c_addr_byte(input logic [6:0] addr, input logic rnw);
    return {addr, rnw};
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - two-flop synchroniser plus consecutive-sample glitch filter
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic raw,
  output logic filt
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Synchronise the bus line, then accept a new level only after FILT_LEN equal samples
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      filt  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_mem.sv
// rtl/i2c_target_mem.sv - I2C target exposing an external 256x8 memory with auto-incrementing pointer
module i2c_target_mem
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEFAULT,
  parameter int         FILT_LEN   = 3
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       wr_done
);

  logic       scl_f;
  logic       sda_f;
  logic       scl_q;
  logic       sda_q;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  i2c_state_e state;
  logic [7:0] shift;
  logic [3:0] bit_cnt;
  logic [7:0] ptr;
  logic       rw_q;
  logic       rack;
  logic [1:0] rd_pipe;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .raw     (scl),
    .filt    (scl_f)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .aclk    (aclk),
    .aresetn (aresetn),
    .raw     (sda_in),
    .filt    (sda_f)
  );

  // SDA may only move while SCL is stably high for START/STOP, so both are SDA edges and never coincide
  always_comb begin
    scl_rise  = scl_f & ~scl_q;
    scl_fall  = ~scl_f & scl_q;
    start_det = scl_f & scl_q & sda_q & ~sda_f;
    stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  end

  // Protocol FSM: bits sampled on SCL rise, SDA changed after SCL fall, read data prefetched during ACK
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      state     <= ST_IDLE;
      sda_oe    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      wr_done   <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      rw_q      <= 1'b0;
      rack      <= NACK;
      rd_pipe   <= '0;
    end else begin
      scl_q   <= scl_f;
      sda_q   <= sda_f;
      mem_we  <= 1'b0;
      wr_done <= 1'b0;
      // mem_addr registered at stage 0, RAM data appears one cycle after that
      rd_pipe <= {rd_pipe[0], 1'b0};
      if (rd_pipe[1]) shift <= mem_rdata;

      if (stop_det) begin
        state   <= ST_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
        rd_pipe <= '0;
      end else if (start_det) begin
        state   <= ST_ADDR;
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
        rd_pipe <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            sda_oe <= 1'b0;
          end

          ST_ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (shift[7:1] == SLAVE_ADDR) begin
                state  <= ST_ADDR_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw_q   <= shift[0];
                if (shift[0]) begin
                  mem_addr <= ptr;
                  rd_pipe  <= 2'b01;
                end
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw_q) begin
                state   <= ST_RD;
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else begin
                state   <= ST_PTR;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
              end
            end
          end

          ST_PTR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              ptr     <= shift;
              state   <= ST_PTR_ACK;
              sda_oe  <= 1'b1;
              bit_cnt <= '0;
            end
          end

          ST_PTR_ACK: begin
            if (scl_fall) begin
              state  <= ST_WR;
              sda_oe <= 1'b0;
            end
          end

          ST_WR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state     <= ST_WR_ACK;
              sda_oe    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= shift;
              mem_we    <= 1'b1;
              wr_done   <= 1'b1;
              ptr       <= ptr + 8'd1;
              bit_cnt   <= '0;
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              state  <= ST_WR;
              sda_oe <= 1'b0;
            end
          end

          ST_RD: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                // Release for the controller's ACK and fetch the following byte speculatively
                state    <= ST_RD_ACK;
                sda_oe   <= 1'b0;
                mem_addr <= ptr + 8'd1;
                rd_pipe  <= 2'b01;
                bit_cnt  <= '0;
              end else begin
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              rack <= sda_f;
            end else if (scl_fall) begin
              if (rack == ACK) begin
                ptr     <= ptr + 8'd1;
                state   <= ST_RD;
                sda_oe  <= ~shift[7];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= 4'd1;
              end else begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
              end
            end
          end

          default: begin
            state  <= ST_IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_mem.sv
// tb/tb_i2c_target_mem.sv - self-checking bench for i2c_target_mem with a bus controller model and 256x8 RAM
module tb_i2c_target_mem;

  localparam int Q = 16;

  logic       aclk;
  logic       aresetn;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       wr_done;

  logic       ctrl_low;
  logic       ram_clr;
  logic [7:0] ram [0:255];

  int errors = 0;
  int checks = 0;

  int we_cnt = 0;
  int wd_cnt = 0;
  int wd_bad = 0;
  int wd_run = 0;
  int pair_bad = 0;
  int busy_cnt = 0;
  logic [7:0] last_addr = 8'h00;
  logic [7:0] last_data = 8'h00;

  i2c_target_mem #(.SLAVE_ADDR(7'h50), .FILT_LEN(3)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .wr_done   (wr_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Open-drain bus: either side pulling low wins
  assign sda_in = ~(sda_oe | ctrl_low);

  // Synchronous 256x8 RAM, one-cycle read latency
  always @(posedge aclk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // Write-strobe and busy monitor
  always @(negedge aclk) begin
    if (mem_we) begin
      we_cnt    = we_cnt + 1;
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
    if (mem_we !== wr_done) pair_bad = pair_bad + 1;
    if (wr_done) begin
      wd_run = wd_run + 1;
    end else begin
      if (wd_run != 0) begin
        wd_cnt = wd_cnt + 1;
        if (wd_run != 1) wd_bad = wd_bad + 1;
      end
      wd_run = 0;
    end
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge aclk);
  endtask

  task automatic bit_cycle(input logic drive_low, output logic sampled);
    ctrl_low = drive_low;
    qwait();
    scl = 1'b1;
    qwait();
    sampled = sda_in;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic i2c_start();
    ctrl_low = 1'b0;
    qwait();
    scl = 1'b1;
    qwait();
    ctrl_low = 1'b1;
    qwait();
    scl = 1'b0;
    qwait();
  endtask

  task automatic i2c_stop();
    ctrl_low = 1'b1;
    qwait();
    scl = 1'b1;
    qwait();
    ctrl_low = 1'b0;
    qwait();
    qwait();
  endtask

  // Returns 1 when the target pulled SDA low in the ninth clock
  task automatic write_byte(input logic [7:0] d, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(~d[i], s);
    bit_cycle(1'b0, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_cycle(1'b0, s);
      d = {d[6:0], s};
    end
    bit_cycle(send_ack, s);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] ptr;
    logic [7:0] data;
    logic       exp_ack;
  } wvec_t;

  wvec_t vecs [4];

  initial begin
    logic       a0;
    logic       a1;
    logic       a2;
    logic [7:0] rd;
    int         we0;
    int         wd0;
    int         bz0;

    vecs[0] = '{dev: 8'hA0, ptr: 8'h03, data: 8'hA5, exp_ack: 1'b1};
    vecs[1] = '{dev: 8'hA0, ptr: 8'h10, data: 8'h3C, exp_ack: 1'b1};
    vecs[2] = '{dev: 8'hA2, ptr: 8'h20, data: 8'h77, exp_ack: 1'b0};
    vecs[3] = '{dev: 8'hA0, ptr: 8'hFF, data: 8'h01, exp_ack: 1'b1};

    scl      = 1'b1;
    ctrl_low = 1'b0;
    aresetn  = 1'b0;
    ram_clr  = 1'b1;
    repeat (4) @(negedge aclk);
    ram_clr = 1'b0;
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_wr_done", wr_done, 0);
    check("reset_mem_addr", mem_addr, 0);
    aresetn = 1'b1;
    qwait();
    check("idle_sda_oe", sda_oe, 0);

    // Single-byte writes, one per table row
    foreach (vecs[v]) begin
      we0 = we_cnt;
      wd0 = wd_bad;
      bz0 = busy_cnt;
      i2c_start();
      write_byte(vecs[v].dev, a0);
      write_byte(vecs[v].ptr, a1);
      write_byte(vecs[v].data, a2);
      i2c_stop();
      check($sformatf("v%0d_addr_ack", v), a0, vecs[v].exp_ack);
      check($sformatf("v%0d_ptr_ack", v), a1, vecs[v].exp_ack);
      check($sformatf("v%0d_data_ack", v), a2, vecs[v].exp_ack);
      check($sformatf("v%0d_we_count", v), we_cnt - we0, vecs[v].exp_ack ? 1 : 0);
      check($sformatf("v%0d_wr_done_width", v), wd_bad - wd0, 0);
      if (vecs[v].exp_ack) begin
        check($sformatf("v%0d_we_addr", v), last_addr, vecs[v].ptr);
        check($sformatf("v%0d_we_data", v), last_data, vecs[v].data);
        check($sformatf("v%0d_ram", v), ram[vecs[v].ptr], vecs[v].data);
      end else begin
        check($sformatf("v%0d_busy_quiet", v), busy_cnt - bz0, 0);
        check($sformatf("v%0d_ram_untouched", v), ram[vecs[v].ptr], 8'h00);
      end
      check($sformatf("v%0d_end_busy", v), busy, 0);
    end
    check("we_wr_done_pairing", pair_bad, 0);

    // Random read with repeated START and NACK
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h03, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    read_byte(1'b0, rd);
    check("rr_acks", {a0, a1, a2}, 3'b111);
    check("rr_data", rd, 8'hA5);
    check("rr_sda_oe_after_nack", sda_oe, 0);
    check("rr_busy_after_nack", busy, 0);
    i2c_stop();

    // Sequential write across the pointer wrap
    we0 = we_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'hFE, a1);
    write_byte(8'h11, a2);
    write_byte(8'h22, a2);
    write_byte(8'h33, a2);
    i2c_stop();
    check("sw_we_count", we_cnt - we0, 3);
    check("sw_ram_fe", ram[8'hFE], 8'h11);
    check("sw_ram_ff", ram[8'hFF], 8'h22);
    check("sw_ram_00", ram[8'h00], 8'h33);

    // Sequential read across the wrap, then a read without pointer phase continues from the pointer
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'hFE, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    read_byte(1'b1, rd);
    check("sr_byte0", rd, 8'h11);
    read_byte(1'b1, rd);
    check("sr_byte1", rd, 8'h22);
    read_byte(1'b0, rd);
    check("sr_byte2", rd, 8'h33);
    i2c_stop();
    i2c_start();
    write_byte(8'hA1, a0);
    read_byte(1'b0, rd);
    i2c_stop();
    check("persist_ack", a0, 1);
    check("persist_data", rd, 8'h33);

    // STOP after four data bits discards the partial byte
    we0 = we_cnt;
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h40, a1);
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, a2);
    i2c_stop();
    check("ps_we_count", we_cnt - we0, 0);
    check("ps_sda_oe", sda_oe, 0);
    check("ps_busy", busy, 0);
    check("ps_ram", ram[8'h40], 8'h00);

    // Reset while the target is pulling SDA low during a read
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h60, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    check("rst_rd_driving", sda_oe, 1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("rst_async_release", sda_oe, 0);
    check("rst_busy", busy, 0);
    repeat (4) @(negedge aclk);
    scl = 1'b1;
    ctrl_low = 1'b0;
    repeat (4) @(negedge aclk);
    aresetn = 1'b1;
    qwait();
    check("rst_quiet_sda", sda_oe, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Served normally after reset
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h61, a1);
    write_byte(8'h5A, a2);
    i2c_stop();
    check("post_rst_acks", {a0, a1, a2}, 3'b111);
    check("post_rst_ram", ram[8'h61], 8'h5A);
    i2c_start();
    write_byte(8'hA0, a0);
    write_byte(8'h61, a1);
    i2c_start();
    write_byte(8'hA1, a2);
    read_byte(1'b0, rd);
    i2c_stop();
    check("post_rst_read", rd, 8'h5A);
    check("final_we_pairing", pair_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
